// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode stage and ID/EX pipeline register.
// Decodes the IF/ID instruction, reads the regfile with a same-cycle WB
// bypass, builds the immediate, detects load-use hazards and registers
// the result into ID/EX with flush/stall bubbles.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            wreg,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wrdata,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_wreg,
  output logic            ex_is_load,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_STORE  = 7'h23;

  // Everything the execute stage needs, carried as one register.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            wreg;
    logic            is_load;
    logic            illegal;
  } idex_t;

  idex_t idex_q, idex_d;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign raddr1 = if_instr[19:15];
  assign raddr2 = if_instr[24:20];

  // Immediate formats, all sign-extended from instr[31]
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                  if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                  if_instr[20], if_instr[30:21], 1'b0};

  logic        uses_rs1, uses_rs2, wr_en, dec_is_load, dec_illegal;
  logic [31:0] dec_imm;

  // Opcode decode: source usage, write enable, immediate format
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave a value unassigned and infer a latch.
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    wr_en       = 1'b0;
    dec_is_load = 1'b0;
    dec_illegal = 1'b0;
    dec_imm     = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        wr_en   = 1'b1;
        dec_imm = imm_u;
      end
      OPC_JAL: begin
        wr_en   = 1'b1;
        dec_imm = imm_j;
      end
      OPC_JALR, OPC_OPIMM: begin
        uses_rs1 = 1'b1;
        wr_en    = 1'b1;
        dec_imm  = imm_i;
      end
      OPC_LOAD: begin
        uses_rs1    = 1'b1;
        wr_en       = 1'b1;
        dec_is_load = 1'b1;
        dec_imm     = imm_i;
      end
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        wr_en    = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_imm  = imm_b;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        dec_imm  = imm_s;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic dec_wreg;
  assign dec_wreg = wr_en && (rd != 5'd0);

  // Operand select: x0 forces zero, then the WB bypass, then the regfile.
  // The bypass is needed because the regfile writes on the same edge.
  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (raddr1 == 5'd0)              ? '0     :
                   (wreg && (waddr == raddr1))   ? wrdata : rdata1;
  assign rs2_val = (raddr2 == 5'd0)              ? '0     :
                   (wreg && (waddr == raddr2))   ? wrdata : rdata2;

  // Load-use: a load in EX whose rd feeds a source this instruction reads
  logic hazard;
  assign hazard = idex_q.valid && idex_q.is_load && (idex_q.rd != 5'd0) && if_valid &&
                  ((uses_rs1 && (raddr1 == idex_q.rd)) ||
                   (uses_rs2 && (raddr2 == idex_q.rd)));

  // A flush redirects the PC upstream, so there is nothing to hold
  assign id_stall = hazard && !flush;

  // ID/EX next state: bubble on flush/hazard, otherwise load the decode
  always_comb begin
    idex_d = '0;
    if (!flush && !hazard && if_valid) begin
      idex_d.valid    = 1'b1;
      idex_d.pc       = if_pc;
      idex_d.rs1_val  = rs1_val;
      idex_d.rs2_val  = rs2_val;
      idex_d.imm      = dec_imm;
      idex_d.rd       = rd;
      idex_d.opcode   = opcode;
      idex_d.funct3   = if_instr[14:12];
      idex_d.funct7b5 = if_instr[30];
      idex_d.wreg     = dec_wreg;
      idex_d.is_load  = dec_is_load;
      idex_d.illegal  = dec_illegal;
    end
  end

  // ID/EX register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the whole pipeline register is reset (it is flops, not a memory),
    // and state is updated with <= so every flop samples pre-edge values.
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign ex_valid    = idex_q.valid;
  assign ex_pc       = idex_q.pc;
  assign ex_rs1_val  = idex_q.rs1_val;
  assign ex_rs2_val  = idex_q.rs2_val;
  assign ex_imm      = idex_q.imm;
  assign ex_rd       = idex_q.rd;
  assign ex_opcode   = idex_q.opcode;
  assign ex_funct3   = idex_q.funct3;
  assign ex_funct7b5 = idex_q.funct7b5;
  assign ex_wreg     = idex_q.wreg;
  assign ex_is_load  = idex_q.is_load;
  assign ex_illegal  = idex_q.illegal;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register for the pipelined RV32I core. It decodes the instruction held in IF/ID, drives the regfile read addresses and takes its read data. It forwards a same-cycle writeback into the read data, generates immediates, and detects load-use hazards. Results are registered into ID/EX for the execute stage, with stall and flush control.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction word from IF/ID
- if_pc  in  32  PC of if_instr
- flush  in  1  taken branch/jump resolved in EX; squash ID/EX load
- raddr1, raddr2  out  5  regfile read addresses (combinational from if_instr[19:15], [24:20])
- rdata1, rdata2  in  32  regfile read data (combinational)
- wreg, waddr, wrdata  in  1/5/32  writeback port snooped for bypass (same signals that drive the regfile)
- id_stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32  registered operands
- ex_rd  out  5; ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1
- ex_wreg, ex_is_load, ex_illegal  out  1  registered control

## Operation
- Register-use decode by opcode:
  - LUI 0x37, AUIPC 0x17, JAL 0x6F: no rs.
  - JALR 0x67, LOAD 0x03, OP-IMM 0x13: rs1 only.
  - OP 0x33, BRANCH 0x63, STORE 0x23: rs1 and rs2.
  - Any other opcode: no rs, wreg=0, illegal=1.
- wreg is 1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP when rd != 0. is_load is 1 only for LOAD.
- Immediate generation, sign-extended to 32 bits from instr[31]:
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - OP/illegal: 0.
- Operand select per source, highest priority first:
  - Address 0 yields 0.
  - Else wreg && waddr==raddr yields wrdata (WB bypass; the regfile writes on the same edge).
  - Else rdata.
- Load-use hazard is declared when ex_valid && ex_is_load && ex_rd != 0 && if_valid, and the current instruction uses a source equal to ex_rd.
- id_stall = hazard && !flush.
- ID/EX next state, by priority:
  1. Reset: all ex_* = 0.
  2. flush=1: bubble. ex_valid=0, ex_wreg=0, ex_is_load=0, other fields don't-care but held at 0.
  3. Hazard: bubble, same as flush.
  4. Otherwise: load decoded fields. ex_valid = if_valid. When if_valid=0, control bits are 0.
- Unused rs fields never trigger a hazard and never change correctness. Their operand value is don't-care.
- A bubble leaves no architectural side effect: ex_wreg=0 and ex_is_load=0.

## Timing
- Decode, bypass and hazard logic are combinational in the ID cycle. ID/EX updates on the next rising clk edge, giving 1-cycle latency from IF/ID to ex_*.
- A load-use stall lasts exactly 1 cycle. The next cycle the load has left EX (ex_is_load=0), so the hazard clears and the held instruction issues.
- A back-to-back dependent chain after a load costs 1 bubble per load only.
- flush and hazard asserted together: bubble is inserted and id_stall=0, because upstream redirects the PC.
- rst_n low asynchronously clears ID/EX, so ex_valid=0 and id_stall=0 immediately.
  - Reset deasserted mid-program: first valid ex_* appears one edge after a valid IF/ID instruction.
- The bypass covers only the WB-to-ID path. EX/MEM forwarding belongs to the execute stage.

## Test plan
- Reset: hold rst_n=0 with if_valid=1 -> all ex_* = 0 and id_stall=0. Release -> ADDI x5,x0,0x7FF (0x7FF00293) gives ex_imm=0x000007FF, ex_rd=5, ex_wreg=1, ex_rs1_val=0.
- Immediates: BEQ x0,x0,-4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_wreg=0. LUI x1,0xABCDE (0xABCDE0B7) -> ex_imm=0xABCDE000.
- WB bypass: regfile x5 holds 0. Assert wreg=1, waddr=5, wrdata=0xA5A5A5A5 while decoding ADD x7,x6,x5 (0x005303B3) -> ex_rs2_val=0xA5A5A5A5. With waddr=0 and wreg=1 -> the x0 read stays 0.
- Load-use: LW x6,4(x5) (0x0042A303) followed by ADD x7,x6,x5.
  - Cycle after the LW reaches EX: id_stall=1, then ex_valid=0.
  - Next cycle: id_stall=0 and ex_valid=1 with ex_rd=7.
  - The same sequence with ADD x7,x5,x5 -> no stall.
- Flush priority: assert flush together with a load-use hazard -> id_stall=0, next ex_valid=0, ex_wreg=0.
- Illegal/x0: opcode 0x7F -> ex_illegal=1, ex_wreg=0, no stall. Load with rd=x0 followed by a use of x0 -> no stall.
